// File: rtl/ptmch_spi_dec_if.sv
// SPI snoop bus between the SPI pins and the command decoder.
// The master modport drives chip select and serial data and observes the
// decoded results; the slave modport is the decoder side.
interface ptmch_spi_dec_if #(
    parameter int P_ABT_W = 8
);
    logic               SPI_CS;
    logic               SPI_MOSI;
    logic [7:0]         OPC;
    logic               OPC_TGL;
    logic [23:0]        ADDR;
    logic [1:0]         ADDR_LEN;
    logic               CMD_TGL;
    logic [P_ABT_W-1:0] ABORT_CNT;

    modport master (
        output SPI_CS, SPI_MOSI,
        input  OPC, OPC_TGL, ADDR, ADDR_LEN, CMD_TGL, ABORT_CNT
    );

    modport slave (
        input  SPI_CS, SPI_MOSI,
        output OPC, OPC_TGL, ADDR, ADDR_LEN, CMD_TGL, ABORT_CNT
    );
endinterface

// File: rtl/ptmch_spi_dec.sv
// SPI NAND snoop command decoder, running entirely on SPI_CLK.
// Frames the opcode and its address field and publishes them with
// toggle-style completion flags for a downstream toggle synchroniser.
// Optional macro PTMCH_DEC_RDCOL_EN: decode 0x03/0x0B with a 16-bit column.
module ptmch_spi_dec #(
    parameter int P_ABT_W = 8
) (
    input  logic               SPI_CLK,
    input  logic               RESET_N,
    ptmch_spi_dec_if.slave     bus
);

    typedef enum logic [1:0] {ST_OPC, ST_ADR, ST_DONE} state_t;

    state_t             state, state_d;
    logic [4:0]         bit_cnt, bit_cnt_d;
    logic [7:0]         opc_sr, opc_sr_d;
    logic [23:0]        addr_sh, addr_sh_d;
    logic [1:0]         adr_len, adr_len_d;
    logic [7:0]         opc, opc_d;
    logic               opc_tgl, opc_tgl_d;
    logic [23:0]        addr, addr_d;
    logic [1:0]         addr_len, addr_len_d;
    logic               cmd_tgl, cmd_tgl_d;
    logic [P_ABT_W-1:0] abort_cnt, abort_d;
    logic               frm_req, frm_ack, new_frm;
    logic [7:0]         opc_full;
    logic [23:0]        addr_full;
    logic [4:0]         adr_last;

    // Address field length code for a completed opcode (0 none, 1/2/3 bytes).
    function automatic logic [1:0] classify(input logic [7:0] code);
        logic [1:0] len;
        len = 2'd0;
        case (code)
            8'h13, 8'h10, 8'hD8:       len = 2'd3;
            8'h0F, 8'h05, 8'h1F, 8'h01: len = 2'd1;
`ifdef PTMCH_DEC_RDCOL_EN
            8'h03, 8'h0B:              len = 2'd2;
`else
            8'h03, 8'h0B:              len = 2'd0;
`endif
            default:                   len = 2'd0;
        endcase
        return len;
    endfunction

    // Frame-start request: raised on SPI_CS rise, acknowledged by the SPI_CLK
    // domain, so repeated CS glitches between frames still mean one new frame.
    always_ff @(posedge bus.SPI_CS or negedge RESET_N) begin
        if (!RESET_N) frm_req <= 1'b0;
        else          frm_req <= ~frm_ack;
    end

    assign new_frm = frm_req ^ frm_ack;

    assign opc_full  = {opc_sr[6:0], bus.SPI_MOSI};
    assign addr_full = {addr_sh[22:0], bus.SPI_MOSI};
    assign adr_last  = {adr_len, 3'b000} - 5'd1;

    // Next-state and output decode for one sampled MOSI bit.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        opc_sr_d   = opc_sr;
        addr_sh_d  = addr_sh;
        adr_len_d  = adr_len;
        opc_d      = opc;
        opc_tgl_d  = opc_tgl;
        addr_d     = addr;
        addr_len_d = addr_len;
        cmd_tgl_d  = cmd_tgl;
        abort_d    = abort_cnt;
        if (!bus.SPI_CS) begin
            if (new_frm) begin
                opc_sr_d  = {7'b0, bus.SPI_MOSI};
                bit_cnt_d = 5'd1;
                state_d   = ST_OPC;
                if (state != ST_DONE && !(&abort_cnt))
                    abort_d = abort_cnt + P_ABT_W'(1);
            end else begin
                case (state)
                    ST_OPC: begin
                        opc_sr_d = opc_full;
                        if (bit_cnt == 5'd7) begin
                            opc_d     = opc_full;
                            opc_tgl_d = ~opc_tgl;
                            addr_sh_d = 24'd0;
                            bit_cnt_d = 5'd0;
                            adr_len_d = classify(opc_full);
                            if (classify(opc_full) == 2'd0) begin
                                cmd_tgl_d  = ~cmd_tgl;
                                addr_len_d = 2'd0;
                                state_d    = ST_DONE;
                            end else begin
                                state_d = ST_ADR;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt + 5'd1;
                        end
                    end
                    ST_ADR: begin
                        addr_sh_d = addr_full;
                        if (bit_cnt == adr_last) begin
                            addr_d     = addr_full;
                            addr_len_d = adr_len;
                            cmd_tgl_d  = ~cmd_tgl;
                            state_d    = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder state register; frame-start acknowledge happens on the first
    // SPI_CLK rise with chip select low.
    always_ff @(posedge SPI_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_DONE;
            bit_cnt   <= 5'd0;
            opc_sr    <= 8'd0;
            addr_sh   <= 24'd0;
            adr_len   <= 2'd0;
            opc       <= 8'd0;
            opc_tgl   <= 1'b0;
            addr      <= 24'd0;
            addr_len  <= 2'd0;
            cmd_tgl   <= 1'b0;
            abort_cnt <= '0;
            frm_ack   <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            opc_sr    <= opc_sr_d;
            addr_sh   <= addr_sh_d;
            adr_len   <= adr_len_d;
            opc       <= opc_d;
            opc_tgl   <= opc_tgl_d;
            addr      <= addr_d;
            addr_len  <= addr_len_d;
            cmd_tgl   <= cmd_tgl_d;
            abort_cnt <= abort_d;
            if (!bus.SPI_CS) frm_ack <= frm_req;
        end
    end

    assign bus.OPC       = opc;
    assign bus.OPC_TGL   = opc_tgl;
    assign bus.ADDR      = addr;
    assign bus.ADDR_LEN  = addr_len;
    assign bus.CMD_TGL   = cmd_tgl;
    assign bus.ABORT_CNT = abort_cnt;

endmodule

// File: tb/tb_ptmch_spi_dec.sv
// Scoreboard bench for ptmch_spi_dec: two instances (8-bit and 2-bit abort
// counters) see identical SPI traffic; expected completions are queued when
// a frame is driven and matched when the toggle flags move.
module tb_ptmch_spi_dec;

    typedef struct {
        bit          is_cmd;
        int          edge_no;
        logic [7:0]  opc;
        logic [23:0] addr;
        logic [1:0]  len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs = 1'b0;
    logic mosi = 1'b0;

    int checks = 0;
    int errors = 0;
    int edge_idx = 0;
    int rst_count = 0;
    exp_t exp_q[$];

    logic [7:0]  m_opc = 8'd0;
    logic [23:0] m_addr = 24'd0;
    logic [1:0]  m_len = 2'd0;
    int          m_abort = 0;
    bit          m_busy = 1'b0;

    ptmch_spi_dec_if #(.P_ABT_W(8)) bus_a ();
    ptmch_spi_dec_if #(.P_ABT_W(2)) bus_b ();

    assign bus_a.SPI_CS   = cs;
    assign bus_a.SPI_MOSI = mosi;
    assign bus_b.SPI_CS   = cs;
    assign bus_b.SPI_MOSI = mosi;

    ptmch_spi_dec #(.P_ABT_W(8)) dut_a (.SPI_CLK(clk), .RESET_N(rst_n), .bus(bus_a.slave));
    ptmch_spi_dec #(.P_ABT_W(2)) dut_b (.SPI_CLK(clk), .RESET_N(rst_n), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] classify(input logic [7:0] code);
        case (code)
            8'h13, 8'h10, 8'hD8:        return 2'd3;
            8'h0F, 8'h05, 8'h1F, 8'h01: return 2'd1;
`ifdef PTMCH_DEC_RDCOL_EN
            8'h03, 8'h0B:               return 2'd2;
`endif
            default:                    return 2'd0;
        endcase
    endfunction

    // Drive one CS-low frame of nbits MSB first, optionally pulsing reset
    // after edge rst_after; queue the completions the frame should produce.
    task automatic applyStimulus(input logic [47:0] data, input int nbits, input int rst_after);
        logic [7:0]  op;
        logic [23:0] ad;
        logic [1:0]  len;
        int          n;
        exp_t        e;
        op = 8'd0;
        ad = 24'd0;
        for (int i = 0; i < nbits && i < 8; i++) op = {op[6:0], data[nbits-1-i]};
        len = (nbits >= 8) ? classify(op) : 2'd0;
        n = 8 * int'(len);
        for (int i = 8; i < nbits && i < 8 + n; i++) ad = {ad[22:0], data[nbits-1-i]};
        if (m_busy && m_abort < 255) m_abort++;
        m_busy = 1'b1;
        if (nbits >= 8) begin
            m_opc = op;
            e = '{1'b0, 8, op, 24'd0, 2'd0};
            exp_q.push_back(e);
            if (nbits >= 8 + n) begin
                if (n != 0) m_addr = ad;
                m_len = len;
                m_busy = 1'b0;
                e = '{1'b1, 8 + n, op, m_addr, len};
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cs = 1'b0;
            mosi = data[nbits-1-i];
            edge_idx = i + 1;
            @(posedge clk);
            #1;
            if (i == 0) begin
                checkOutput("abort_a", 32'(bus_a.ABORT_CNT), 32'(m_abort));
                checkOutput("abort_b", 32'(bus_b.ABORT_CNT), 32'((m_abort > 3) ? 3 : m_abort));
            end
            if (i + 1 == rst_after) begin
                rst_n = 1'b0;
                rst_count++;
                #1;
                checkOutput("rst_opc", 32'(bus_a.OPC), 32'd0);
                checkOutput("rst_addr", 32'(bus_a.ADDR), 32'd0);
                checkOutput("rst_tgl", {30'd0, bus_a.OPC_TGL, bus_a.CMD_TGL}, 32'd0);
                #1;
                rst_n = 1'b1;
                m_opc = 8'd0;
                m_addr = 24'd0;
                m_len = 2'd0;
                m_abort = 0;
                m_busy = 1'b0;
                exp_q.delete();
            end
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        checkOutput("frm_opc", 32'(bus_a.OPC), 32'(m_opc));
        checkOutput("frm_addr", 32'(bus_a.ADDR), 32'(m_addr));
        checkOutput("frm_len", 32'(bus_a.ADDR_LEN), 32'(m_len));
    endtask

    // Toggle monitor: each flag movement must match the next queued completion.
    initial begin
        logic prev_o, prev_c;
        int   seen_rst;
        exp_t e;
        prev_o = 1'b0;
        prev_c = 1'b0;
        seen_rst = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_count != seen_rst) begin
                seen_rst = rst_count;
                prev_o = bus_a.OPC_TGL;
                prev_c = bus_a.CMD_TGL;
            end else begin
                if (bus_a.OPC_TGL !== prev_o) begin
                    if (exp_q.size() == 0 || exp_q[0].is_cmd) begin
                        checkOutput("opc_tgl_unexp", 32'(bus_a.OPC_TGL), 32'(prev_o));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("opc_edge", 32'(edge_idx), 32'(e.edge_no));
                        checkOutput("opc_val", 32'(bus_a.OPC), 32'(e.opc));
                    end
                    prev_o = bus_a.OPC_TGL;
                end
                if (bus_a.CMD_TGL !== prev_c) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_cmd) begin
                        checkOutput("cmd_tgl_unexp", 32'(bus_a.CMD_TGL), 32'(prev_c));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("cmd_edge", 32'(edge_idx), 32'(e.edge_no));
                        checkOutput("cmd_addr", 32'(bus_a.ADDR), 32'(e.addr));
                        checkOutput("cmd_len", 32'(bus_a.ADDR_LEN), 32'(e.len));
                    end
                    prev_c = bus_a.CMD_TGL;
                end
            end
        end
    end

    // Directed frames from the test plan followed by a short random mix.
    initial begin
        logic [7:0]  ops [11];
        logic [7:0]  op;
        logic [47:0] d;
        int          n;
        ops = '{8'h06, 8'h13, 8'h10, 8'hD8, 8'h0F, 8'h05, 8'h1F, 8'h01, 8'h03, 8'h0B, 8'h9F};
        #12;
        checkOutput("reset_opc", 32'(bus_a.OPC), 32'd0);
        checkOutput("reset_abort", 32'(bus_a.ABORT_CNT), 32'd0);
        checkOutput("reset_len", 32'(bus_a.ADDR_LEN), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(48'h06, 8, 0);
        applyStimulus(48'h13001234, 32, 0);
        applyStimulus(48'h0FC0ABCD, 32, 0);
        applyStimulus(48'hD8001, 20, 0);
        applyStimulus(48'h06, 8, 0);
        applyStimulus(48'h41234, 22, 12);
        applyStimulus(48'h05A0, 16, 0);
        for (int k = 0; k < 5; k++) applyStimulus(48'hA, 4, 0);
        applyStimulus(48'h06, 8, 0);
        applyStimulus(48'h031234, 24, 0);

        for (int k = 0; k < 8; k++) begin
            op = ops[$urandom_range(0, 10)];
            n = 8 * int'(classify(op));
            d = (48'(op) << n) | (48'($urandom()) & ((48'd1 << n) - 48'd1));
            applyStimulus(d, 8 + n, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptmch_spi_dec.md
Name: ptmch_spi_dec

Overview:
SPI-clock-domain command decoder for the SPI NAND snoop path. It samples SPI_MOSI on SPI_CLK while SPI_CS is low, frames the opcode and the opcode-dependent address field, and publishes opcode and address with toggle-style completion flags. The downstream 160 MHz pattern-match/trigger stage synchronises these flags. All decode is done here on the SPI clock, so that stage needs no bit-level reassembly.

Parameters:
P_ABT_W, 8, width of saturating aborted-frame counter ABORT_CNT

Ports:
SPI_CLK  input  1  SPI serial clock; MOSI sampled on rising edge (mode 0)
RESET_N  input  1  asynchronous, active-low reset
SPI_CS  input  1  chip select, active low; rising edge marks end of frame
SPI_MOSI  input  1  serial data, MSB first
OPC  output  8  last fully received opcode
OPC_TGL  output  1  toggles once per completed opcode byte
ADDR  output  24  last completed address field, right-aligned, MSB first; zero-extended
ADDR_LEN  output  2  length of ADDR field: 0 none, 1 = 8 bit, 2 = 16 bit, 3 = 24 bit
CMD_TGL  output  1  toggles once per completed command (opcode + full address field)
ABORT_CNT  output  P_ABT_W  saturating count of frames truncated before command completion

Behaviour:
- Reset: RESET_N is asynchronous, active-low; clock is SPI_CLK. RESET_N low forces OPC=0, ADDR=0, ADDR_LEN=0, OPC_TGL=0, CMD_TGL=0, ABORT_CNT=0, state=DONE, new_frm=0. RESET_N low dominates SPI_CS.
- new_frm flag: asynchronously set by SPI_CS rising edge; cleared on the first SPI_CLK rise with SPI_CS low.
- Because new_frm resets to 0, decoding after reset starts only after the next SPI_CS deassert. The remainder of any frame in progress at reset is ignored.
- States: OPC (opcode bits, bit_cnt 0..7), ADR (address bits, bit_cnt 0..N-1), DONE (ignore bits until next frame). SPI_CLK edges with SPI_CS high are ignored.
- First edge of a frame (new_frm=1): sample bit7 of the opcode, set bit_cnt=1, enter OPC.
  - In the same edge, if the previous state was OPC or ADR (frame truncated), ABORT_CNT increments, saturating at all-ones.
- 8th opcode edge: OPC is loaded with the full byte registered on that edge, and OPC_TGL toggles. Classification:
  - 0x13, 0x10, 0xD8: ADR with N=24 (dummy byte + 16-bit page address; page = ADDR[15:0]).
  - 0x0F, 0x05, 0x1F, 0x01: ADR with N=8.
  - All others: N=0. CMD_TGL toggles on this same edge, ADDR_LEN=0, ADDR unchanged, state goes to DONE.
- ADR: shift bits into an internal shifter; ADDR/ADDR_LEN are untouched during the shift. On the Nth address edge, ADDR is loaded with the zero-extended shifter value, ADDR_LEN is set, CMD_TGL toggles, and state goes to DONE.
- Data and dummy bits after completion are ignored (DONE) until SPI_CS rises.
- Latency:
  - OPC/OPC_TGL are valid immediately after the 8th SPI_CLK rising edge.
  - ADDR/CMD_TGL are valid immediately after edge 8+N.
  - Outputs hold until the next completion (at least 8 SPI_CLK edges later), so the consumer may sample them after a 2-flop toggle sync.
- Truncated frames: OPC, ADDR and CMD_TGL are not updated for an incomplete field. A truncated opcode leaves OPC/OPC_TGL unchanged. A truncated address leaves ADDR/CMD_TGL unchanged.
- Abort detection is registered at the first edge of the following frame. A truncated final frame is never counted.
- SPI_CS glitch-high within a frame is treated as a frame boundary.

Optional Feature:
PTMCH_DEC_RDCOL_EN
- Defined: opcodes 0x03 and 0x0B are classified N=16 (column address). They load ADDR[15:0], set ADDR[23:16]=0 and ADDR_LEN=2, and toggle CMD_TGL at edge 24.
- Undefined: 0x03 and 0x0B are opcode-only (N=0). CMD_TGL toggles at edge 8 and ADDR_LEN=0.

Test Plan:
- Frame 0x06, 8 clocks, CS high -> edge 8: OPC=0x06, OPC_TGL and CMD_TGL both toggle, ADDR_LEN=0, ADDR unchanged; ABORT_CNT=0.
- Frame 0x13 00 12 34 -> edge 8: OPC=0x13, OPC_TGL toggles, CMD_TGL not yet; edge 32: ADDR=0x001234, ADDR_LEN=3, CMD_TGL toggles once.
- Frame 0x0F C0 + 16 data bits -> edge 16: ADDR=0x0000C0, ADDR_LEN=1, CMD_TGL toggles; following 16 bits cause no output change.
- Frame 0xD8 cut after 20 bits, then frame 0x06 -> no CMD_TGL for 0xD8; ABORT_CNT goes 0->1 at the first edge of the 0x06 frame; 0x06 then decodes as in test 1.
- RESET_N pulsed low after 12 bits of 0x10 frame, then 10 more clocks, CS high, frame 0x05 0xA0 -> no toggles before the new frame; OPC=0x05, ADDR=0x0000A0, ABORT_CNT=0.
- P_ABT_W=2, five 4-bit truncated frames then 0x06 -> ABORT_CNT saturates at 3. With PTMCH_DEC_RDCOL_EN, frame 0x03 12 34 -> ADDR=0x001234, ADDR_LEN=2, CMD_TGL at edge 24; without the macro -> CMD_TGL at edge 8, ADDR_LEN=0.
